// File: rtl/ce_output_packer.sv
// Packs pairs of AXI-Stream samples into words and writes them sequentially into the CE output buffer.
// It holds each finished frame until software acknowledges it, and flags frames too long for the buffer.
module ce_output_packer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [SAMPLE_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      buf_wr_en,
  output logic [ADDR_WIDTH-1:0]     buf_wr_addr,
  output logic [2*SAMPLE_WIDTH-1:0] buf_wr_data,
  input  logic                      buf_ack,
  output logic                      frame_done,
  output logic [ADDR_WIDTH:0]       frame_words,
  output logic                      overflow
);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    ST_HI   = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_WORDS = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                    state_reg, state_next;
  logic [SAMPLE_WIDTH-1:0]   lo_reg, lo_next;
  logic [ADDR_WIDTH:0]       count_reg, count_next;
  logic                      wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0]     wr_addr_reg, wr_addr_next;
  logic [2*SAMPLE_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic                      frame_done_reg, frame_done_next;
  logic [ADDR_WIDTH:0]       frame_words_reg, frame_words_next;
  logic                      overflow_reg, overflow_next;

  logic                      accept;
  logic [ADDR_WIDTH:0]       count_inc;

  // Ready is forced low while reset is held so nothing is handshaken then.
  assign s_axis_tready = (state_reg != ST_DONE) && !ARESET;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign count_inc     = count_reg + 1'b1;

  // State register and all registered datapath/outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg       <= ST_LO;
      lo_reg          <= '0;
      count_reg       <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      frame_done_reg  <= 1'b0;
      frame_words_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lo_reg          <= lo_next;
      count_reg       <= count_next;
      wr_en_reg       <= wr_en_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      frame_done_reg  <= frame_done_next;
      frame_words_reg <= frame_words_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LO: begin
        if (accept) begin
          state_next = s_axis_tlast ? ST_DONE : ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          if (s_axis_tlast) begin
            state_next = ST_DONE;
          end else if (count_inc == DEPTH_WORDS) begin
            state_next = ST_DROP;
          end else begin
            state_next = ST_LO;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (buf_ack) begin
          state_next = ST_LO;
        end
      end
      default: state_next = ST_LO;
    endcase
  end

  // Output/datapath logic; values land in registers so writes appear one cycle after accept.
  always_comb begin
    lo_next          = lo_reg;
    count_next       = count_reg;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    frame_words_next = frame_words_reg;
    overflow_next    = overflow_reg;
    frame_done_next  = (state_next == ST_DONE) && (state_reg != ST_DONE);

    case (state_reg)
      ST_LO: begin
        if (accept) begin
          lo_next = s_axis_tdata;
          if (s_axis_tlast) begin
            // Odd trailing sample is written alone with a zero upper half.
            wr_en_next       = 1'b1;
            wr_addr_next     = count_reg[ADDR_WIDTH-1:0];
            wr_data_next     = {{SAMPLE_WIDTH{1'b0}}, s_axis_tdata};
            count_next       = count_inc;
            frame_words_next = count_inc;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          wr_en_next   = 1'b1;
          wr_addr_next = count_reg[ADDR_WIDTH-1:0];
          wr_data_next = {s_axis_tdata, lo_reg};
          count_next   = count_inc;
          if (s_axis_tlast) begin
            frame_words_next = count_inc;
          end else if (count_inc == DEPTH_WORDS) begin
            overflow_next = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          frame_words_next = count_reg;
        end
      end
      ST_DONE: begin
        if (buf_ack) begin
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      default: begin
        count_next = '0;
      end
    endcase
  end

  assign buf_wr_en   = wr_en_reg;
  assign buf_wr_addr = wr_addr_reg;
  assign buf_wr_data = wr_data_reg;
  assign frame_done  = frame_done_reg;
  assign frame_words = frame_words_reg;
  assign overflow    = overflow_reg;

endmodule
